down_count_checker: RTL and testbench

- Downstream consumer of the 4-bit dataflow down counter: samples the counter output `q` every enabled clock.
- Checks that each sample equals the previous sample minus one (mod 2^WIDTH).
- Produces a terminal-count pulse, a wrap counter, mismatch/error counters and a sticky fault flag.
- Lets the lab bench check counter behaviour in hardware instead of by waveform inspection.

---
 rtl/down_count_checker.sv | 208 ++++++++++++++++++++
 tb/tb_down_count_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/down_count_checker.sv
// -----------------------------------------------------------------------------
// down_count_checker
//
// Watches the output of a WIDTH-bit down counter and checks that every enabled
// sample is exactly one less than the previous enabled sample (mod 2^WIDTH).
// The first enabled sample after reset only seeds the reference value. After
// that the block tracks the sequence. It counts wraps (0 -> max) and
// mismatches. After ERR_LIMIT mismatches it enters a sticky fault state that
// only rst clears.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-high reset, clears all state
//   en         in   sample enable; q is examined only on edges with en=1
//   q          in   [WIDTH-1:0] monitored counter value
//   tc         out  1-cycle pulse: last enabled sample had q==0
//   mismatch   out  1-cycle pulse: last enabled sample broke the sequence
//   locked     out  high while tracking the sequence
//   fault      out  sticky fault flag, high until rst
//   wrap_count out  [WRAP_W-1:0] saturating count of 0 -> max transitions
//   err_count  out  [ERR_W-1:0]  saturating count of mismatches
//
// All outputs are registered. A sample taken on edge N shows on the outputs
// just after edge N.
// -----------------------------------------------------------------------------
module down_count_checker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              mismatch,
  output logic              locked,
  output logic              fault,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count
);

  // Encoding 3 is never entered on purpose. If it is ever seen, the FSM
  // returns to IDLE and reseeds from the next enabled sample.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2,
    ST_SPARE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  Q_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_LIM  = ERR_W'(ERR_LIMIT);

  // Saturating increment helpers. The counters stick at all-ones.
  function automatic logic [WRAP_W-1:0] wrap_sat_inc(input logic [WRAP_W-1:0] v);
    logic [WRAP_W-1:0] r;
    if (v == WRAP_MAX) begin
      r = v;
    end else begin
      r = v + WRAP_ONE;
    end
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == ERR_MAX) begin
      r = v;
    end else begin
      r = v + ERR_ONE;
    end
    return r;
  endfunction

  // State and datapath registers
  state_t            state_r;
  logic [WIDTH-1:0]  prev_r;
  logic              tc_r;
  logic              mismatch_r;
  logic              locked_r;
  logic              fault_r;
  logic [WRAP_W-1:0] wrap_r;
  logic [ERR_W-1:0]  err_r;

  // Next-state values
  state_t            next_state_s;
  logic [WIDTH-1:0]  prev_d_s;
  logic              tc_d_s;
  logic              mismatch_d_s;
  logic [WRAP_W-1:0] wrap_d_s;
  logic [ERR_W-1:0]  err_d_s;

  // Comparison helpers
  logic [WIDTH-1:0]  expected_s;
  logic              match_s;
  logic              prev_zero_s;
  logic              q_zero_s;
  logic [WRAP_W-1:0] wrap_inc_s;
  logic [ERR_W-1:0]  err_inc_s;

  // Expected next value and the flags derived from the current sample
  always_comb begin
    expected_s  = prev_r - Q_ONE;  // truncation gives 0 -> max
    match_s     = (q == expected_s);
    prev_zero_s = (prev_r == Q_ZERO);
    q_zero_s    = (q == Q_ZERO);
    wrap_inc_s  = wrap_sat_inc(wrap_r);
    err_inc_s   = err_sat_inc(err_r);
  end

  // FSM next-state and datapath update. Defaults hold state and clear pulses.
  always_comb begin
    next_state_s = state_r;
    prev_d_s     = prev_r;
    tc_d_s       = 1'b0;
    mismatch_d_s = 1'b0;
    wrap_d_s     = wrap_r;
    err_d_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        // The first sample only seeds prev. No comparison is made.
        if (en) begin
          prev_d_s     = q;
          tc_d_s       = q_zero_s;
          next_state_s = ST_TRACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (en) begin
          // Resync to the observed value on match and mismatch alike, so a
          // single glitch costs one error instead of an error per sample.
          prev_d_s = q;
          tc_d_s   = q_zero_s;
          if (match_s) begin
            if (prev_zero_s) begin
              wrap_d_s = wrap_inc_s;
            end else begin
              wrap_d_s = wrap_r;
            end
            next_state_s = ST_TRACK;
          end else begin
            // A mismatching sample never counts as a wrap, even if prev was 0.
            mismatch_d_s = 1'b1;
            err_d_s      = err_inc_s;
            if (err_inc_s == ERR_LIM) begin
              next_state_s = ST_FAULT;
            end else begin
              next_state_s = ST_TRACK;
            end
          end
        end else begin
          next_state_s = ST_TRACK;
        end
      end
      ST_FAULT: begin
        // Frozen until rst: samples are ignored and counters hold.
        next_state_s = ST_FAULT;
      end
      ST_SPARE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      prev_r     <= Q_ZERO;
      tc_r       <= 1'b0;
      mismatch_r <= 1'b0;
      locked_r   <= 1'b0;
      fault_r    <= 1'b0;
      wrap_r     <= {WRAP_W{1'b0}};
      err_r      <= {ERR_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      prev_r     <= prev_d_s;
      tc_r       <= tc_d_s;
      mismatch_r <= mismatch_d_s;
      // locked/fault are registered copies of the state they describe
      locked_r   <= (next_state_s == ST_TRACK);
      fault_r    <= (next_state_s == ST_FAULT);
      wrap_r     <= wrap_d_s;
      err_r      <= err_d_s;
    end
  end

  assign tc         = tc_r;
  assign mismatch   = mismatch_r;
  assign locked     = locked_r;
  assign fault      = fault_r;
  assign wrap_count = wrap_r;
  assign err_count  = err_r;

endmodule

// File: tb/tb_down_count_checker.sv
module tb_down_count_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q;
  logic       tc;
  logic       mismatch;
  logic       locked;
  logic       fault;
  logic [1:0] wrap_count;
  logic [7:0] err_count;

  int total;
  int bad;

  down_count_checker #(
    .WIDTH(4), .WRAP_W(2), .ERR_W(8), .ERR_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .q(q),
    .tc(tc), .mismatch(mismatch), .locked(locked), .fault(fault),
    .wrap_count(wrap_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] qv;
    logic       x_tc;
    logic       x_mm;
    logic       x_lk;
    logic       x_ft;
    logic [7:0] x_wr;
    logic [7:0] x_er;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic r, input logic e, input logic [3:0] qv,
                     input logic x_tc, input logic x_mm, input logic x_lk,
                     input logic x_ft, input logic [7:0] x_wr, input logic [7:0] x_er);
    vec_t v;
    v.r = r; v.e = e; v.qv = qv;
    v.x_tc = x_tc; v.x_mm = x_mm; v.x_lk = x_lk; v.x_ft = x_ft;
    v.x_wr = x_wr; v.x_er = x_er;
    tab.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic x_tc, input logic x_mm,
                           input logic x_lk, input logic x_ft,
                           input logic [7:0] x_wr, input logic [7:0] x_er);
    check("tc", idx, {7'd0, tc}, {7'd0, x_tc});
    check("mismatch", idx, {7'd0, mismatch}, {7'd0, x_mm});
    check("locked", idx, {7'd0, locked}, {7'd0, x_lk});
    check("fault", idx, {7'd0, fault}, {7'd0, x_ft});
    check("wrap_count", idx, {6'd0, wrap_count}, x_wr);
    check("err_count", idx, err_count, x_er);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.r; en = v.e; q = v.qv;
    @(posedge clk);
    #1;
    check_all(idx, v.x_tc, v.x_mm, v.x_lk, v.x_ft, v.x_wr, v.x_er);
  endtask

  int split;

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; q = 4'd0;

    // Scenario 1: full 15..0 run and one wrap
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int v = 15; v >= 1; v--)
      add(1'b0, 1'b1, 4'(v), 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
    // Scenario 2: resync after a mismatch
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
    add(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1);
    // Unexpected q=0: tc and mismatch together
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
    // Prev=0 but q != 15: mismatch only, no wrap
    add(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd2);
    // Scenario 4: enable gating, first-sample q=0 gives tc from IDLE
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b0, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    // Scenario 3: three mismatches -> fault, then frozen
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1);
    add(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd2);
    add(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd3);
    add(1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    add(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    add(1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    add(1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    add(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd3);
    split = tab.size();
    // Scenario 5 (after async reset): reseed and track
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

    for (int i = 0; i < split; i++) apply(i, tab[i]);

    // Scenario 5: rst between edges clears every output without a clock
    #3;
    rst = 1'b1;
    #1;
    check_all(1000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    for (int i = split; i < tab.size(); i++) apply(i, tab[i]);

    // Scenario 6: four full runs then 15, 2-bit wrap counter saturates at 3
    begin
      vec_t v;
      int step;
      int wexp;
      step = 2000;
      v.r = 1'b1; v.e = 1'b0; v.qv = 4'd0;
      v.x_tc = 1'b0; v.x_mm = 1'b0; v.x_lk = 1'b0; v.x_ft = 1'b0;
      v.x_wr = 8'd0; v.x_er = 8'd0;
      apply(step, v);
      for (int c = 0; c <= 4; c++) begin
        wexp = (c > 3) ? 3 : c;
        for (int s = 15; s >= 0; s--) begin
          if (c == 4 && s < 15) break;
          step++;
          v.r = 1'b0; v.e = 1'b1; v.qv = 4'(s);
          v.x_tc = (s == 0);
          v.x_mm = 1'b0; v.x_lk = 1'b1; v.x_ft = 1'b0;
          v.x_wr = 8'(wexp); v.x_er = 8'd0;
          apply(step, v);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
